pos_total_renderer: RTL and testbench

Pixel-generation stage of the POS display path, directly upstream of the top-level RGB buffer. It accumulates item prices entered on the switches into a running total and converts the total to BCD with a sequential double-dabble. It then renders the total as four seven-segment-style digits into the 8-bit red/green/blue streams, using the x/y/video_on/p_tick outputs of `vgasync`.

---
 rtl/pos_total_renderer.sv | 178 +++++++++++++++++
 tb/tb_pos_total_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pos_total_renderer.sv
// POS running-total accumulator with sequential BCD conversion and
// a four-digit seven-segment pixel renderer feeding the RGB buffer.
module pos_total_renderer #(
    parameter int          X0        = 224,
    parameter int          Y0        = 200,
    parameter logic [23:0] FG        = 24'h00FF00,
    parameter logic [23:0] BG        = 24'h000000,
    parameter int          MAX_TOTAL = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [7:0]  sw,
    input  logic        add,
    input  logic        clear,
    output logic [13:0] total,
    output logic        busy,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t       r_state;
    logic         r_go;
    logic         r_busy;
    logic [3:0]   r_cnt;
    logic [29:0]  r_sr;
    logic [15:0]  r_dig;
    logic [13:0]  r_total;
    logic [23:0]  r_rgb;

    logic         w_accept;
    logic [14:0]  w_sum;
    logic [13:0]  w_sat;
    logic [29:0]  w_adj;

    assign w_accept = (r_state == S_IDLE) && !r_go && !r_busy && (add || clear);
    assign w_sum    = {1'b0, r_total} + {7'd0, sw};
    assign w_sat    = (w_sum > 15'(MAX_TOTAL)) ? 14'(MAX_TOTAL) : w_sum[13:0];

    // Double-dabble correction applied to the BCD field before each shift
    always_comb begin
        w_adj = r_sr;
        for (int n = 0; n < 4; n++) begin
            if (r_sr[14+4*n +: 4] >= 4'd5)
                w_adj[14+4*n +: 4] = r_sr[14+4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            r_sr    <= 30'd0;
            r_dig   <= 16'd0;
            r_total <= 14'd0;
        end else begin
            if (w_accept) begin
                r_total <= clear ? 14'd0 : w_sat;
                r_go    <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (r_go) begin
                        r_go    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sr    <= {16'd0, r_total};
                    r_cnt   <= 4'd0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_sr  <= {w_adj[28:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_dig   <= r_sr[29:14];
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic        w_yin;
    logic        w_in;
    logic        w_blank;
    logic [9:0]  w_cx;
    logic [9:0]  w_cy;
    logic [3:0]  w_d;
    logic [3:0]  w_bl;
    logic [6:0]  w_seg;
    logic        w_lit;

    // A digit is blanked while it and every higher digit are zero
    assign w_bl[3] = (r_dig[15:12] == 4'd0);
    assign w_bl[2] = w_bl[3] && (r_dig[11:8] == 4'd0);
    assign w_bl[1] = w_bl[2] && (r_dig[7:4] == 4'd0);
    assign w_bl[0] = 1'b0;

    assign w_yin = (y >= 10'(Y0)) && (y <= 10'(Y0 + 79));
    assign w_cy  = y - 10'(Y0);

    always_comb begin
        w_in    = 1'b0;
        w_cx    = 10'd0;
        w_d     = 4'd0;
        w_blank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_yin && (x >= 10'(X0 + (3 - i) * 48))
                      && (x <= 10'(X0 + (3 - i) * 48 + 47))) begin
                w_in    = 1'b1;
                w_cx    = x - 10'(X0 + (3 - i) * 48);
                w_d     = r_dig[4*i +: 4];
                w_blank = w_bl[i];
            end
        end
    end

    always_comb begin
        unique case (w_d)
            4'd0:    w_seg = 7'b1111110;
            4'd1:    w_seg = 7'b0110000;
            4'd2:    w_seg = 7'b1101101;
            4'd3:    w_seg = 7'b1111001;
            4'd4:    w_seg = 7'b0110011;
            4'd5:    w_seg = 7'b1011011;
            4'd6:    w_seg = 7'b1011111;
            4'd7:    w_seg = 7'b1110000;
            4'd8:    w_seg = 7'b1111111;
            4'd9:    w_seg = 7'b1111011;
            default: w_seg = 7'b0000000;
        endcase
    end

    assign w_lit =
        (w_seg[6] && w_cx <= 10'd39 && w_cy <= 10'd7) ||
        (w_seg[5] && w_cx >= 10'd32 && w_cx <= 10'd39 && w_cy <= 10'd39) ||
        (w_seg[4] && w_cx >= 10'd32 && w_cx <= 10'd39 &&
                     w_cy >= 10'd32 && w_cy <= 10'd71) ||
        (w_seg[3] && w_cx <= 10'd39 && w_cy >= 10'd64 && w_cy <= 10'd71) ||
        (w_seg[2] && w_cx <= 10'd7 && w_cy >= 10'd32 && w_cy <= 10'd71) ||
        (w_seg[1] && w_cx <= 10'd7 && w_cy <= 10'd39) ||
        (w_seg[0] && w_cx <= 10'd39 && w_cy >= 10'd32 && w_cy <= 10'd39);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= 24'd0;
        end else if (p_tick) begin
            if (!video_on)
                r_rgb <= 24'd0;
            else if (w_in && !w_blank && w_lit)
                r_rgb <= FG;
            else
                r_rgb <= BG;
        end
    end

    assign total = r_total;
    assign busy  = r_busy;
    assign red   = r_rgb[23:16];
    assign green = r_rgb[15:8];
    assign blue  = r_rgb[7:0];

endmodule

// File: tb/tb_pos_total_renderer.sv
// Randomised scoreboard bench for pos_total_renderer: pixel colours are
// predicted from the digit-layout rules and checked by a separate monitor.
module tb_pos_total_renderer;

    localparam logic [23:0] FGC = 24'h00FF00;
    localparam logic [23:0] BGC = 24'h000000;

    localparam logic [6:0] SEG [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
                                        7'b1111001, 7'b0110011, 7'b1011011,
                                        7'b1011111, 7'b1110000, 7'b1111111,
                                        7'b1111011};
    localparam int RX0 [7] = '{0, 32, 32, 0, 0, 0, 0};
    localparam int RX1 [7] = '{39, 39, 39, 39, 7, 7, 39};
    localparam int RY0 [7] = '{0, 0, 32, 64, 32, 0, 32};
    localparam int RY1 [7] = '{7, 39, 71, 71, 71, 39, 39};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [7:0]  sw = '0;
    logic        add = 1'b0;
    logic        clear = 1'b0;
    logic [13:0] total;
    logic        busy;
    logic [7:0]  red, green, blue;

    int errors = 0;
    int checks = 0;
    int m_total = 0;
    int m_disp = 0;
    logic [23:0] q[$];
    logic [23:0] last_exp = '0;
    logic tick_prev = 1'b0;
    logic rst_prev = 1'b1;

    pos_total_renderer dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .sw(sw), .add(add), .clear(clear),
        .total(total), .busy(busy), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_pix(int px, int py, bit von, int val);
        int left, p10, d, cx, cy;
        if (!von) return 24'd0;
        for (int i = 0; i < 4; i++) begin
            left = 224 + (3 - i) * 48;
            if (px >= left && px < left + 48 && py >= 200 && py < 280) begin
                p10 = 10 ** i;
                if (i > 0 && val < p10) return BGC;
                d  = (val / p10) % 10;
                cx = px - left;
                cy = py - 200;
                for (int s = 0; s < 7; s++)
                    if (SEG[d][6-s] && cx >= RX0[s] && cx <= RX1[s]
                        && cy >= RY0[s] && cy <= RY1[s])
                        return FGC;
                return BGC;
            end
        end
        return BGC;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        tick_prev <= p_tick;
        rst_prev  <= reset;
    end

    // Monitor: pops on every pixel tick, otherwise checks the output holds
    always @(negedge clk) begin
        logic [23:0] act, exp;
        act = {red, green, blue};
        if (rst_prev) begin
            exp = 24'd0;
            last_exp = 24'd0;
        end else if (tick_prev) begin
            if (q.size() == 0) begin
                exp = last_exp;
                errors++;
                $display("FAIL pix_underflow: got %06h expected none", act);
            end else begin
                exp = q.pop_front();
                last_exp = exp;
            end
        end else begin
            exp = last_exp;
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL pixel(t=%0t): got %06h expected %06h", $time, act, exp);
        end
    end

    task automatic pix(input int px, input int py, input bit v);
        @(negedge clk);
        x = 10'(px); y = 10'(py); video_on = v; p_tick = 1'b1;
        q.push_back(ref_pix(px, py, v, m_disp));
        @(negedge clk);
        p_tick = 1'b0;
    endtask

    task automatic rand_pix(input int n);
        for (int k = 0; k < n; k++)
            pix($urandom_range(200, 430), $urandom_range(190, 290),
                $urandom_range(0, 7) != 0);
    endtask

    task automatic cmd(input bit a, input bit c, input int s,
                       input int inj, output int hi);
        @(negedge clk);
        add = a; clear = c; sw = 8'(s);
        if (c) m_total = 0;
        else if (a) m_total = (m_total + s > 9999) ? 9999 : m_total + s;
        @(negedge clk);
        add = 1'b0; clear = 1'b0;
        chk("total_update", int'(total), m_total);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) hi++;
            if (k == inj) begin add = 1'b1; sw = 8'd100; end
            else add = 1'b0;
            @(negedge clk);
        end
        add = 1'b0;
        m_disp = m_total;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_total", int'(total), 0);
        chk("reset_busy", int'(busy), 0);
        pix(378, 202, 1);
        pix(234, 202, 1);
        pix(10, 10, 1);
        pix(378, 202, 0);
        rand_pix(10);

        for (int k = 0; k < 3; k++) begin
            cmd(1, 0, 250, -1, hi);
            chk("busy_len_add", hi, 16);
        end
        chk("total_750", int'(total), 750);
        pix(305, 210, 1);
        pix(313, 210, 1);
        pix(234, 202, 1);
        rand_pix(30);

        cmd(0, 1, 0, -1, hi);
        chk("busy_len_clear", hi, 16);
        for (int k = 0; k < 38; k++) cmd(1, 0, 255, -1, hi);
        cmd(1, 0, 210, -1, hi);
        chk("total_9900", int'(total), 9900);
        cmd(1, 0, 255, -1, hi);
        chk("total_sat", int'(total), 9999);
        cmd(1, 0, 255, -1, hi);
        chk("total_sat_hold", int'(total), 9999);
        rand_pix(30);

        cmd(1, 1, 200, -1, hi);
        chk("clear_wins", int'(total), 0);
        chk("busy_len_conflict", hi, 16);
        cmd(1, 0, 5, 4, hi);
        chk("busy_add_ignored", int'(total), 5);
        chk("busy_no_retrigger", hi, 16);
        rand_pix(10);

        @(negedge clk);
        add = 1'b1; sw = 8'd7;
        @(negedge clk);
        add = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_total = 0; m_disp = 0;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_total", int'(total), 0);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) hi++;
            @(negedge clk);
        end
        chk("midreset_idle", hi, 0);
        pix(378, 202, 1);
        pix(234, 202, 1);
        cmd(1, 0, 3, -1, hi);
        chk("busy_len_after_reset", hi, 16);

        @(negedge clk);
        x = 10'd367; y = 10'd202; video_on = 1'b1; p_tick = 1'b1;
        q.push_back(ref_pix(367, 202, 1, m_disp));
        @(negedge clk);
        p_tick = 1'b0; x = 10'd378;
        @(negedge clk);
        p_tick = 1'b1;
        q.push_back(ref_pix(378, 202, 1, m_disp));
        @(negedge clk);
        p_tick = 1'b0; x = 10'd367;
        @(negedge clk);
        p_tick = 1'b1;
        q.push_back(ref_pix(367, 202, 1, m_disp));
        @(negedge clk);
        p_tick = 1'b0;
        rand_pix(20);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
